// File: rtl/min_sec_timer.sv
// rtl/min_sec_timer.sv - MM:SS BCD timer with tick prescaler, clear/load, up/down count and sticky done
module min_sec_timer #(
  parameter int TICK_CYCLES = 100_000,
  parameter int MIN_MOD     = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        down,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] ld_val,
  output logic [3:0]  s0,
  output logic [3:0]  s1,
  output logic [3:0]  m0,
  output logic [3:0]  m1,
  output logic        tick,
  output logic        rollover,
  output logic        done
);

  localparam int            PW     = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PMAX   = PW'(TICK_CYCLES - 1);
  localparam logic [3:0]    M1_MAX = 4'(MIN_MOD / 10 - 1);

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [PW-1:0] presc;
  logic [3:0]    n_s0, n_s1, n_m0, n_m1;
  logic          wrap;
  logic          n_zero;
  logic [15:0]   ld_clamped;

  // The prescaler only advances while running and not done, so tick is gated the same way.
  assign tick = run & ~done & (presc == PMAX);

  assign ld_clamped = {clamp(ld_val[15:12], M1_MAX), clamp(ld_val[11:8], 4'd9),
                       clamp(ld_val[7:4], 4'd5), clamp(ld_val[3:0], 4'd9)};

  // Next digit values for one count step in the current direction.
  always_comb begin
    n_s0 = s0;
    n_s1 = s1;
    n_m0 = m0;
    n_m1 = m1;
    wrap = 1'b0;
    if (!down) begin
      if (s0 == 4'd9) begin
        n_s0 = 4'd0;
        if (s1 == 4'd5) begin
          n_s1 = 4'd0;
          if (m0 == 4'd9) begin
            n_m0 = 4'd0;
            if (m1 == M1_MAX) begin
              n_m1 = 4'd0;
              wrap = 1'b1;
            end else begin
              n_m1 = m1 + 4'd1;
            end
          end else begin
            n_m0 = m0 + 4'd1;
          end
        end else begin
          n_s1 = s1 + 4'd1;
        end
      end else begin
        n_s0 = s0 + 4'd1;
      end
    end else if ({m1, m0, s1, s0} != 16'h0) begin
      // At 00:00 the digits hold; there is no underflow wrap.
      if (s0 == 4'd0) begin
        n_s0 = 4'd9;
        if (s1 == 4'd0) begin
          n_s1 = 4'd5;
          if (m0 == 4'd0) begin
            n_m0 = 4'd9;
            n_m1 = m1 - 4'd1;
          end else begin
            n_m0 = m0 - 4'd1;
          end
        end else begin
          n_s1 = s1 - 4'd1;
        end
      end else begin
        n_s0 = s0 - 4'd1;
      end
    end
    n_zero = ({n_m1, n_m0, n_s1, n_s0} == 16'h0);
  end

  // State update: rst > clr > load > tick-driven count.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      {m1, m0, s1, s0} <= 16'h0;
      rollover <= 1'b0;
      done     <= 1'b0;
    end else if (clr) begin
      presc    <= '0;
      {m1, m0, s1, s0} <= 16'h0;
      rollover <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      presc    <= '0;
      {m1, m0, s1, s0} <= ld_clamped;
      rollover <= 1'b0;
      done     <= down & (ld_val == 16'h0);
    end else begin
      rollover <= 1'b0;
      if (run && !done)
        presc <= (presc == PMAX) ? '0 : presc + PW'(1);
      if (tick) begin
        {m1, m0, s1, s0} <= {n_m1, n_m0, n_s1, n_s0};
        if (down)
          done <= n_zero;
        else
          rollover <= wrap;
      end
    end
  end

endmodule

// File: tb/tb_min_sec_timer.sv
// tb/tb_min_sec_timer.sv - randomized and directed check of min_sec_timer against a seconds-count model
module tb_min_sec_timer;

  localparam int TC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        down = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] ld_val = 16'h0;

  logic [3:0] a_s0, a_s1, a_m0, a_m1, b_s0, b_s1, b_m0, b_m1;
  logic       a_tick, a_roll, a_done, b_tick, b_roll, b_done;

  min_sec_timer #(.TICK_CYCLES(TC), .MIN_MOD(60)) dut_a (
    .clk(clk), .rst(rst), .run(run), .down(down), .clr(clr), .load(load), .ld_val(ld_val),
    .s0(a_s0), .s1(a_s1), .m0(a_m0), .m1(a_m1), .tick(a_tick), .rollover(a_roll), .done(a_done));

  min_sec_timer #(.TICK_CYCLES(TC), .MIN_MOD(100)) dut_b (
    .clk(clk), .rst(rst), .run(run), .down(down), .clr(clr), .load(load), .ld_val(ld_val),
    .s0(b_s0), .s1(b_s1), .m0(b_m0), .m1(b_m1), .tick(b_tick), .rollover(b_roll), .done(b_done));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit en = 1'b0;

  // Model: value kept as total seconds, phase as an integer counter.
  int mm[2] = '{60, 100};
  int secs[2];
  int ph[2];
  bit md[2];
  bit mr[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int ld_secs(input logic [15:0] v, input int k);
    int d3, d2, d1, d0;
    d3 = int'(v[15:12]); d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
    if (d3 > mm[k] / 10 - 1) d3 = mm[k] / 10 - 1;
    if (d2 > 9) d2 = 9;
    if (d1 > 5) d1 = 5;
    if (d0 > 9) d0 = 9;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit t;
      t = run && !md[k] && ph[k] == TC - 1;
      mr[k] = 1'b0;
      if (rst || clr) begin
        secs[k] = 0; md[k] = 1'b0; ph[k] = 0;
      end else if (load) begin
        secs[k] = ld_secs(ld_val, k); md[k] = down && ld_val == 16'h0; ph[k] = 0;
      end else begin
        if (run && !md[k]) ph[k] = (ph[k] + 1) % TC;
        if (t) begin
          if (!down) begin
            secs[k] = (secs[k] + 1) % (mm[k] * 60);
            mr[k] = (secs[k] == 0);
          end else begin
            if (secs[k] != 0) secs[k] = secs[k] - 1;
            if (secs[k] == 0) md[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic cmp(input int k, input logic [3:0] s0, s1, m0, m1, input logic tk, rl, dn);
    int m, s;
    m = secs[k] / 60; s = secs[k] % 60;
    chk($sformatf("dut%0d_s0", k), int'(s0), s % 10);
    chk($sformatf("dut%0d_s1", k), int'(s1), s / 10);
    chk($sformatf("dut%0d_m0", k), int'(m0), m % 10);
    chk($sformatf("dut%0d_m1", k), int'(m1), m / 10);
    chk($sformatf("dut%0d_tick", k), int'(tk), int'(run && !md[k] && ph[k] == TC - 1));
    chk($sformatf("dut%0d_rollover", k), int'(rl), int'(mr[k]));
    chk($sformatf("dut%0d_done", k), int'(dn), int'(md[k]));
  endtask

  // Every cycle after the first reset, both DUTs are compared against the model.
  always @(negedge clk) begin
    if (en) begin
      cmp(0, a_s0, a_s1, a_m0, a_m1, a_tick, a_roll, a_done);
      cmp(1, b_s0, b_s1, b_m0, b_m1, b_tick, b_roll, b_done);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    step(1);
    en = 1'b1;
    chk("reset_digits", int'({a_m1, a_m0, a_s1, a_s0}), 0);
    chk("reset_flags", int'({a_tick, a_roll, a_done}), 0);

    // Stopwatch from cleared state: ten ticks give 00:10.
    rst = 1'b0; run = 1'b1;
    step(40);
    chk("t1_s1", int'(a_s1), 1);
    chk("t1_s0", int'(a_s0), 0);

    // Up-mode wrap from 59:58.
    load = 1'b1; ld_val = 16'h5958; step(1); load = 1'b0;
    step(8);
    chk("t2_wrap_digits", int'({a_m1, a_m0, a_s1, a_s0}), 0);
    chk("t2_wrap_roll", int'(a_roll), 1);
    chk("t2_b_noroll", int'({b_m1, b_m0, b_s1, b_s0, 3'b0, b_roll}), 32'h6000_0);
    step(1);
    chk("t2_roll_pulse", int'(a_roll), 0);
    step(3);
    chk("t2_after", int'({a_m1, a_m0, a_s1, a_s0}), 16'h0001);
    load = 1'b1; ld_val = 16'h9959; step(1); load = 1'b0;
    step(4);
    chk("t2_b_wrap", int'({b_m1, b_m0, b_s1, b_s0}), 0);
    chk("t2_b_roll", int'(b_roll), 1);

    // Countdown from 01:00 to done, then holds.
    down = 1'b1; load = 1'b1; ld_val = 16'h0100; step(1); load = 1'b0;
    step(4);
    chk("t3_first", int'({a_m1, a_m0, a_s1, a_s0}), 16'h0059);
    step(236);
    chk("t3_zero", int'({a_m1, a_m0, a_s1, a_s0}), 0);
    chk("t3_done", int'(a_done), 1);
    step(32);
    chk("t3_hold_done", int'(a_done), 1);

    // Clamping and load-zero in down mode.
    run = 1'b0; down = 1'b0; load = 1'b1; ld_val = 16'hF9A7; step(1);
    chk("t4_clamp_a", int'({a_m1, a_m0, a_s1, a_s0}), 16'h5957);
    chk("t4_clamp_b", int'({b_m1, b_m0, b_s1, b_s0}), 16'h9957);
    chk("t4_done_clr", int'(a_done), 0);
    down = 1'b1; ld_val = 16'h0000; step(1); load = 1'b0;
    chk("t4_load0_done", int'(a_done), 1);

    // Pause keeps phase; clr coincident with tick discards it.
    down = 1'b0; load = 1'b1; ld_val = 16'h0005; step(1); load = 1'b0;
    run = 1'b1; step(2);
    run = 1'b0; step(10);
    run = 1'b1; step(1);
    chk("t5_tick_after_pause", int'(a_tick), 1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("t5_clr_digits", int'({a_m1, a_m0, a_s1, a_s0}), 0);
    chk("t5_clr_roll_tick", int'({a_roll, a_tick}), 0);

    // Reset mid-countdown restarts the prescaler.
    down = 1'b1; load = 1'b1; ld_val = 16'h1234; step(1); load = 1'b0;
    step(6);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t6_rst", int'({a_m1, a_m0, a_s1, a_s0, a_tick, a_roll, a_done}), 0);
    step(3);
    chk("t6_first_tick", int'(a_tick), 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       ld_val = 16'h0;
        1:       ld_val = 16'(($urandom_range(0, 1) * 16'h5900) | 16'h0059);
        default: ld_val = 16'($urandom);
      endcase
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) down = ~down;
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/min_sec_timer.md
Name: min_sec_timer

Overview:
- Parametrised successor to the cascaded min:sec digit counter.
- Four BCD digits MM:SS with true mod-60 seconds and a selectable minutes modulus.
- Built-in tick prescaler, run/pause, synchronous clear, parallel load, and up (stopwatch) or down (countdown) mode with a sticky done flag.
- Drives the lab display path and the alarm/countdown logic.

Parameters:
- TICK_CYCLES, 100_000: clk cycles per count tick (1 ms at 100 MHz); must be >= 2.
- MIN_MOD, 60: minutes modulus; legal values 60 or 100. m1 ranges 0..5 or 0..9 accordingly.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = prescaler advances and digits count on tick; 0 = pause.
- down  in  1  level; 0 = count up, 1 = count down; sampled at each tick.
- clr  in  1  one-cycle sync clear to 00:00.
- load  in  1  one-cycle parallel load of ld_val.
- ld_val  in  16  {m1,m0,s1,s0} BCD load value.
- s0, s1, m0, m1  out  4 each  registered BCD digits.
- tick  out  1  one-cycle pulse when the prescaler wraps.
- rollover  out  1  one-cycle pulse on up-mode wrap from max to 00:00.
- done  out  1  sticky; countdown reached 00:00.

Behaviour:
- Reset: rst=1 at a clock edge sets s0=s1=m0=m1=0, prescaler=0, tick=0, rollover=0, done=0.
- Priority when events coincide: rst > clr > load > tick-driven count.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 only while run=1 and done=0.
  - tick=1 in the cycle the prescaler holds TICK_CYCLES-1; it wraps to 0 on the next edge.
  - run=0 freezes the prescaler, so phase is retained across pause.
  - clr and load zero the prescaler.
  - First tick comes TICK_CYCLES cycles after run rises from a cleared state.
- Count update: digits change on the edge that samples tick=1 (one-cycle latency from tick to new value).
- Up mode (down=0):
  - s0 9->0 carries to s1; s1 5->0 carries to m0; m0 9->0 carries to m1.
  - m1 at MIN_MOD/10-1 wraps to 0.
  - From max (59:59, or 99:59 when MIN_MOD=100), the tick gives 00:00 and rollover=1 for that one cycle, registered with the wrap.
  - done is never set in up mode.
- Down mode (down=1):
  - s0 0->9 borrows; s1 0->5 borrows; m0 0->9 borrows.
  - The tick that brings the value to 00:00 sets done=1 on the same edge.
  - While done=1 the prescaler holds and digits hold at 00:00.
  - A tick at 00:00 with done=0 (reached via mode switch) sets done=1 and leaves the digits unchanged; there is no underflow wrap.
- done clears only on clr, load, or rst. Toggling down does not clear it.
- clr: digits become 00:00, done=0, prescaler=0, on the next edge.
- load:
  - Digits take ld_val on the next edge; done=0 and prescaler=0.
  - Exception: if down=1 and ld_val is 00:00, done=1 on that edge.
  - Out-of-range digits clamp per digit: s0,m0 >9 -> 9; s1 >5 -> 5; m1 > MIN_MOD/10-1 -> that limit.
- Mid-operation:
  - Changing down between ticks takes effect at the next tick.
  - rst or clr coincident with tick discards the tick, and rollover/done stay 0.
  - load coincident with tick discards the tick.
- rollover and tick are never asserted for more than one consecutive cycle.

Test Plan:
1. TICK_CYCLES=4, rst then run=1 for 40 cycles -> tick every 4th cycle; s1:s0 goes 00..09 then 10; value 00:10 after tick #10.
2. load 16'h5958, down=0, run=1 -> after 2 ticks 00:00 with rollover=1 for exactly one cycle; next tick 00:01. With MIN_MOD=100, load 16'h9959 -> one tick gives 00:00 plus rollover.
3. down=1, load 16'h0100, run -> 00:59, 00:58 ... at the 60th tick 00:00 and done=1; 8 further periods: digits and done stay unchanged, tick stays 0.
4. load 16'hF9A7 with MIN_MOD=60 -> digits 5,9,5,7 (m1 clamped to 5, s1 clamped to 5); down=1, load 16'h0000 -> done=1 next cycle.
5. Pause: run=0 for 10 cycles after prescaler=2 -> no tick; run=1 -> tick 1 cycle later (phase kept). clr asserted in the same cycle as tick -> 00:00, rollover=0, prescaler=0.
6. rst asserted mid-countdown at 12:34, done=0 -> all outputs 0 on the next edge; with run held at 1, the first tick comes TICK_CYCLES cycles after rst falls.
